// File: rtl/famicom_joyport_ctrl_if.sv
// ---------------------------------------------------------------------------
// famicom_joyport_ctrl_if
// Bundles the controller-port bus between the CPU-side pins and the pad
// shift registers.
//   strobe  : OUT0 latch strobe, 1 = parallel load
//   ncup    : per-channel read strobe, 0 = read in progress
//   buttons : packed button state, channel c at [c*BITS +: BITS], 1 = pressed
//   sdata   : current serial bit per channel, 1 = pressed
//   overrun : sticky per-channel read-past-end flag
// master = CPU/board side, slave = the shift-register block.
// ---------------------------------------------------------------------------
interface famicom_joyport_ctrl_if #(
  parameter int CHANNELS = 2,
  parameter int BITS     = 8
);
  logic                     strobe;
  logic [CHANNELS-1:0]      ncup;
  logic [CHANNELS*BITS-1:0] buttons;
  logic [CHANNELS-1:0]      sdata;
  logic [CHANNELS-1:0]      overrun;

  modport master (output strobe, output ncup, output buttons,
                  input  sdata,  input  overrun);
  modport slave  (input  strobe, input  ncup, input  buttons,
                  output sdata,  output overrun);
endinterface

// File: rtl/famicom_joyport_ctrl.sv
// ---------------------------------------------------------------------------
// famicom_joyport_ctrl
// N-channel 4021-style parallel-in/serial-out controller port model.
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   bus   : famicom_joyport_ctrl_if.slave (strobe, ncup, buttons in;
//           sdata, overrun out)
// Each channel loads {SIG_VALUE, buttons} while strobe is high and shifts
// one bit toward bit 0 on every rising edge of its ncup line. After
// BITS+SIG_BITS shifts the line reads FILL_BIT; one more edge sets the
// sticky overrun flag, which only a load or reset clears.
// SIG_VALUE is carried in a 32-bit parameter; only the low SIG_BITS bits
// are used, so SIG_BITS must not exceed 32.
// ---------------------------------------------------------------------------
module famicom_joyport_ctrl #(
  parameter int          CHANNELS  = 2,
  parameter int          BITS      = 8,
  parameter int          SIG_BITS  = 0,
  parameter logic [31:0] SIG_VALUE = 32'd0,
  parameter bit          FILL_BIT  = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  famicom_joyport_ctrl_if.slave       bus
);

  localparam int TOTAL = BITS + SIG_BITS;
  localparam int CNT_W = $clog2(TOTAL + 1);

  logic [CHANNELS-1:0] w_sdata;
  logic [CHANNELS-1:0] w_overrun;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [TOTAL-1:0] r_sreg;
      logic [CNT_W-1:0] r_cnt;
      logic             r_ovr;
      logic             r_cup_q;
      logic [TOTAL-1:0] w_load;
      logic [TOTAL-1:0] w_shift;
      logic             w_rise;

      // Signature tail sits above the button bits so it streams out last.
      if (SIG_BITS > 0) begin : g_sig
        assign w_load = {SIG_VALUE[SIG_BITS-1:0], bus.buttons[gi*BITS +: BITS]};
      end else begin : g_nosig
        assign w_load = bus.buttons[gi*BITS +: BITS];
      end

      if (TOTAL > 1) begin : g_wide
        assign w_shift = {FILL_BIT, r_sreg[TOTAL-1:1]};
      end else begin : g_single
        assign w_shift = FILL_BIT;
      end

      // End of a read: previous sample low, current sample high.
      assign w_rise = ~r_cup_q & bus.ncup[gi];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_sreg  <= {TOTAL{FILL_BIT}};
          r_cnt   <= '0;
          r_ovr   <= 1'b0;
          r_cup_q <= 1'b1;
        end else begin
          r_cup_q <= bus.ncup[gi];
          if (bus.strobe) begin
            // Transparent load; a coincident read edge is dropped.
            r_sreg <= w_load;
            r_cnt  <= '0;
            r_ovr  <= 1'b0;
          end else if (w_rise) begin
            r_sreg <= w_shift;
            if (r_cnt == CNT_W'(TOTAL)) begin
              r_ovr <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      end

      assign w_sdata[gi]   = r_sreg[0];
      assign w_overrun[gi] = r_ovr;
    end
  endgenerate

  assign bus.sdata   = w_sdata;
  assign bus.overrun = w_overrun;

endmodule

// File: doc/famicom_joyport_ctrl.md
Name: famicom_joyport_ctrl

Overview:
- Parametrised model of the Famicom controller-port serial path: per-channel parallel-in/serial-out shift register (4021 style), driven by the CPU OUT0 strobe and per-port read strobes.
- Generalises the fixed two-port, 8-bit board wiring to N channels, configurable report length and an optional multitap signature tail.
- Adds per-channel overrun status.
- Sits between the CPU OUT0/nINPx pins and the LS368 data buffers, in place of the discrete pad logic behind port2/port4/port5.

Parameters:
- CHANNELS, 2, number of independent controller ports.
- BITS, 8, button bits per channel, shifted LSB first.
- SIG_BITS, 0, signature bits appended after the button bits (0 = none).
- SIG_VALUE, 0, SIG_BITS-wide signature pattern, LSB shifted first.
- FILL_BIT, 1, value shifted into the register MSB and returned after exhaustion.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- STROBE  in  1  OUT0 latch strobe, synchronous to CLK; 1 = parallel load.
- nCUP  in  CHANNELS  per-channel read strobe, synchronous to CLK; 0 = read in progress.
- BUTTONS  in  CHANNELS*BITS  button state, 1 = pressed; channel c uses bits [c*BITS +: BITS].
- SDATA  out  CHANNELS  current serial bit per channel, 1 = pressed, post-inversion polarity.
- OVERRUN  out  CHANNELS  sticky flag: read past the end of the report.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST). All state registers on posedge CLK / posedge RST.
- TOTAL = BITS + SIG_BITS. Per channel:
  - sreg, TOTAL bits.
  - cnt, width clog2(TOTAL+1).
  - ovr, 1 bit.
  - cup_q, registered copy of nCUP[c] for edge detection.
- Reset values:
  - sreg = all FILL_BIT, so SDATA = FILL_BIT.
  - cnt = 0.
  - OVERRUN = 0.
  - cup_q = 1.
- SDATA[c] = sreg[c][0], combinational from the register. Zero latency after a load or shift edge.
- Load: whenever STROBE = 1, every cycle:
  - sreg[c] <= {SIG_VALUE, BUTTONS slice c}.
  - cnt <= 0, ovr <= 0.
  - Load is transparent: button changes while STROBE is held are tracked.
  - The value held when STROBE falls is the last loaded value.
- Shift event:
  - Triggers on cup_q = 0 and nCUP[c] = 1 (rising edge, end of read) while STROBE = 0.
  - sreg[c] <= {FILL_BIT, sreg[c][TOTAL-1:1]}.
  - If cnt < TOTAL, cnt increments.
  - If cnt == TOTAL, cnt holds and ovr <= 1.
- Reads (nCUP low) do not alter state; only the rising edge shifts.
- Simultaneous STROBE = 1 and a rising edge: load wins and the shift is discarded.
- Channels are fully independent; simultaneous edges on several channels all shift in the same cycle.
- Exhaustion:
  - After TOTAL shifts, SDATA = FILL_BIT permanently until the next load.
  - The (TOTAL+1)th edge sets OVERRUN.
- OVERRUN clears only on load or RST.
- RST mid-read or mid-strobe returns to reset values immediately. The first rising nCUP edge after release is detected only against cup_q = 1, so a strobe already high at release is not a spurious edge.
- The SIG_BITS = 0 configuration must synthesise with no signature logic. Use generate guards; zero-width slices are not allowed.

Test Plan:
1. Reset release, defaults, STROBE = 0, no reads -> SDATA = 2'b11, OVERRUN = 2'b00.
2. BUTTONS ch0 = 8'hA5, STROBE pulse 1 cycle, then 8 nCUP[0] low/high pulses -> SDATA[0] sequence before each rising edge is 1,0,1,0,0,1,0,1. After the 8th edge SDATA[0] = 1 and OVERRUN[0] = 0. Channel 1 is unchanged.
3. Continue with a 9th nCUP[0] pulse -> OVERRUN[0] = 1 and SDATA[0] = 1. Next STROBE clears OVERRUN[0] to 0 and reloads bit 0.
4. SIG_BITS = 8, SIG_VALUE = 8'h10, BUTTONS ch1 = 8'h01, 16 reads -> ch1 serial stream is 1,0,0,0,0,0,0,0, then 0,0,0,0,1,0,0,0. OVERRUN is set only on the 17th read.
5. Assert STROBE in the same cycle as a rising edge of nCUP[0] -> no shift: cnt = 0 and SDATA[0] = BUTTONS bit 0. Change BUTTONS while STROBE is held -> SDATA follows one cycle later.
6. Assert RST asynchronously after 3 shifts, between clock edges -> SDATA = FILL_BIT and OVERRUN = 0 immediately. After release, a new strobe and 8 reads give the full report from bit 0.
